// File: rtl/axi2mem_tcdm_arb_if.sv
// rtl/axi2mem_tcdm_arb_if.sv - Requester, TCDM and completion signals of the two-channel TCDM arbiter.
// slave modport is the arbiter's view; master modport is the surrounding AXI2MEM/TCDM side.
interface axi2mem_tcdm_arb_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 6
);
    localparam int BE_WIDTH = DATA_WIDTH / 8;

    logic [1:0]                 req_i;
    logic [1:0][ADDR_WIDTH-1:0] add_i;
    logic [1:0]                 wen_i;
    logic [1:0][DATA_WIDTH-1:0] wdata_i;
    logic [1:0][BE_WIDTH-1:0]   be_i;
    logic [1:0]                 last_i;
    logic [1:0][ID_WIDTH-1:0]   id_i;
    logic [1:0]                 gnt_o;

    logic                       tcdm_req_o;
    logic [ADDR_WIDTH-1:0]      tcdm_add_o;
    logic                       tcdm_wen_o;
    logic [DATA_WIDTH-1:0]      tcdm_wdata_o;
    logic [BE_WIDTH-1:0]        tcdm_be_o;
    logic                       tcdm_gnt_i;
    logic                       tcdm_r_valid_i;
    logic [DATA_WIDTH-1:0]      tcdm_r_rdata_i;

    logic [1:0]                 r_valid_o;
    logic [DATA_WIDTH-1:0]      r_rdata_o;
    logic [1:0]                 done_o;
    logic [1:0][ID_WIDTH-1:0]   done_id_o;

    modport slave (
        input  req_i, add_i, wen_i, wdata_i, be_i, last_i, id_i,
        input  tcdm_gnt_i, tcdm_r_valid_i, tcdm_r_rdata_i,
        output gnt_o, tcdm_req_o, tcdm_add_o, tcdm_wen_o, tcdm_wdata_o, tcdm_be_o,
        output r_valid_o, r_rdata_o, done_o, done_id_o
    );

    modport master (
        output req_i, add_i, wen_i, wdata_i, be_i, last_i, id_i,
        output tcdm_gnt_i, tcdm_r_valid_i, tcdm_r_rdata_i,
        input  gnt_o, tcdm_req_o, tcdm_add_o, tcdm_wen_o, tcdm_wdata_o, tcdm_be_o,
        input  r_valid_o, r_rdata_o, done_o, done_id_o
    );
endinterface

// File: rtl/axi2mem_tcdm_arb.sv
// rtl/axi2mem_tcdm_arb.sv - Round-robin arbiter of AXI2MEM read/write beats onto one TCDM port with response routing.
// Define AXI2MEM_ARB_BURST_LOCK_EN to keep the port with one requester until its last beat.
module axi2mem_tcdm_arb #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 6
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    axi2mem_tcdm_arb_if.slave       bus
);
    localparam int BE_WIDTH = DATA_WIDTH / 8;

    logic                       rr_q, rr_d;
    logic                       sel;
    logic                       grant;

    logic                       resp_pend_q, resp_pend_d;
    logic                       resp_sel_q, resp_sel_d;
    logic                       resp_last_q, resp_last_d;
    logic [ID_WIDTH-1:0]        resp_id_q, resp_id_d;
    logic [1:0][ID_WIDTH-1:0]   done_id_q, done_id_d;
    logic [1:0]                 r_valid;
    logic [1:0]                 done;

    logic [ADDR_WIDTH-1:0]      add_sel;
    logic [DATA_WIDTH-1:0]      wdata_sel;
    logic [BE_WIDTH-1:0]        be_sel;

`ifdef AXI2MEM_ARB_BURST_LOCK_EN
    typedef enum logic {IDLE, LOCKED} state_e;

    state_e state_q, state_d;
    logic   owner_q, owner_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end

    // While locked the other requester is masked even if the owner pauses mid-burst.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        rr_d    = rr_q;
        sel     = rr_q;
        if (state_q == LOCKED) begin
            sel = owner_q;
        end else if (!bus.req_i[rr_q] && bus.req_i[~rr_q]) begin
            sel = ~rr_q;
        end
        grant = bus.tcdm_gnt_i & bus.req_i[sel];
        if (grant) begin
            if (state_q == IDLE) begin
                rr_d = ~sel;
                if (!bus.last_i[sel]) begin
                    state_d = LOCKED;
                    owner_d = sel;
                end
            end else if (bus.last_i[sel]) begin
                state_d = IDLE;
                rr_d    = ~sel;
            end
        end
    end
`else
    always_comb begin
        sel = rr_q;
        if (!bus.req_i[rr_q] && bus.req_i[~rr_q]) begin
            sel = ~rr_q;
        end
        grant = bus.tcdm_gnt_i & bus.req_i[sel];
        rr_d  = grant ? ~sel : rr_q;
    end
`endif

    assign add_sel          = bus.add_i[sel];
    assign wdata_sel        = bus.wdata_i[sel];
    assign be_sel           = bus.be_i[sel];
    assign bus.tcdm_req_o   = bus.req_i[sel];
    assign bus.tcdm_add_o   = add_sel;
    assign bus.tcdm_wen_o   = bus.wen_i[sel];
    assign bus.tcdm_wdata_o = wdata_sel;
    assign bus.tcdm_be_o    = be_sel;

    always_comb begin
        bus.gnt_o      = 2'b00;
        bus.gnt_o[sel] = grant;
    end

    // A new grant overwrites the tracker in the same cycle the previous response is routed.
    always_comb begin
        resp_pend_d = 1'b0;
        resp_sel_d  = resp_sel_q;
        resp_last_d = resp_last_q;
        resp_id_d   = resp_id_q;
        if (grant) begin
            resp_pend_d = 1'b1;
            resp_sel_d  = sel;
            resp_last_d = bus.last_i[sel];
            resp_id_d   = bus.id_i[sel];
        end
    end

    always_comb begin
        r_valid             = 2'b00;
        done                = 2'b00;
        done_id_d           = done_id_q;
        r_valid[resp_sel_q] = bus.tcdm_r_valid_i & resp_pend_q;
        done[resp_sel_q]    = bus.tcdm_r_valid_i & resp_pend_q & resp_last_q;
        if (done[resp_sel_q]) begin
            done_id_d[resp_sel_q] = resp_id_q;
        end
    end

    assign bus.r_valid_o = r_valid;
    assign bus.r_rdata_o = bus.tcdm_r_rdata_i;
    assign bus.done_o    = done;
    assign bus.done_id_o = done_id_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q        <= 1'b0;
            resp_pend_q <= 1'b0;
            resp_sel_q  <= 1'b0;
            resp_last_q <= 1'b0;
            resp_id_q   <= '0;
            done_id_q   <= '0;
        end else begin
            rr_q        <= rr_d;
            resp_pend_q <= resp_pend_d;
            resp_sel_q  <= resp_sel_d;
            resp_last_q <= resp_last_d;
            resp_id_q   <= resp_id_d;
            done_id_q   <= done_id_d;
        end
    end
endmodule

// File: tb/tb_axi2mem_tcdm_arb.sv
// tb/tb_axi2mem_tcdm_arb.sv - Directed self-checking bench for axi2mem_tcdm_arb.
module tb_axi2mem_tcdm_arb;
    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;

    logic [1:0] exp_g    [5];
    logic [1:0] exp_done [5];
    logic       t4_req0  [5];
    logic       t4_last0 [5];
    logic [1:0] exp_rv;

    always #5 clk = ~clk;

    axi2mem_tcdm_arb_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(6)) bus ();

    axi2mem_tcdm_arb #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(6)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
`ifdef AXI2MEM_ARB_BURST_LOCK_EN
        exp_g    = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
        exp_done = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b01};
        t4_req0  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        t4_last0 = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
`else
        exp_g    = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01};
        exp_done = '{2'b00, 2'b00, 2'b10, 2'b00, 2'b10};
        t4_req0  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        t4_last0 = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
        rst_n              = 1'b0;
        bus.req_i          = 2'b00;
        bus.add_i[0]       = 32'h0000_0100;
        bus.add_i[1]       = 32'h0000_0200;
        bus.wen_i          = 2'b01;
        bus.wdata_i[0]     = 32'hAAAA_0000;
        bus.wdata_i[1]     = 32'hBBBB_1111;
        bus.be_i[0]        = 4'hF;
        bus.be_i[1]        = 4'h3;
        bus.last_i         = 2'b00;
        bus.id_i[0]        = 6'd5;
        bus.id_i[1]        = 6'd9;
        bus.tcdm_gnt_i     = 1'b0;
        bus.tcdm_r_valid_i = 1'b0;
        bus.tcdm_r_rdata_i = 32'h0;

        // Reset state
        @(negedge clk);
        chk("rst_gnt", bus.gnt_o, 2'b00);
        chk("rst_tcdm_req", bus.tcdm_req_o, 1'b0);
        chk("rst_r_valid", bus.r_valid_o, 2'b00);
        chk("rst_done", bus.done_o, 2'b00);
        chk("rst_done_id", bus.done_id_o, 12'h0);
        tick();
        rst_n = 1'b1;

        // Both requesting, single-beat bursts: strict alternation
        bus.req_i      = 2'b11;
        bus.last_i     = 2'b11;
        bus.tcdm_gnt_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.tcdm_r_valid_i = (i > 0);
            bus.tcdm_r_rdata_i = 32'hD000_0000 + i;
            @(negedge clk);
            exp_rv = (i == 0) ? 2'b00 : ((i % 2 == 1) ? 2'b01 : 2'b10);
            chk($sformatf("alt_gnt%0d", i), bus.gnt_o, (i % 2 == 0) ? 2'b01 : 2'b10);
            chk($sformatf("alt_add%0d", i), bus.tcdm_add_o, (i % 2 == 0) ? 32'h100 : 32'h200);
            chk($sformatf("alt_wen%0d", i), bus.tcdm_wen_o, (i % 2 == 0) ? 1'b1 : 1'b0);
            chk($sformatf("alt_be%0d", i), bus.tcdm_be_o, (i % 2 == 0) ? 4'hF : 4'h3);
            chk($sformatf("alt_rvalid%0d", i), bus.r_valid_o, exp_rv);
            chk($sformatf("alt_done%0d", i), bus.done_o, exp_rv);
            if (i == 1) chk("alt_done_id0", bus.done_id_o[0], 6'd5);
            if (i == 2) chk("alt_done_id1", bus.done_id_o[1], 6'd9);
            if (i == 3) chk("alt_rdata", bus.r_rdata_o, 32'hD000_0003);
            tick();
        end
        bus.req_i          = 2'b00;
        bus.tcdm_r_valid_i = 1'b1;
        @(negedge clk);
        chk("alt_drain_gnt", bus.gnt_o, 2'b00);
        chk("alt_drain_req", bus.tcdm_req_o, 1'b0);
        chk("alt_drain_rvalid", bus.r_valid_o, 2'b10);
        chk("alt_drain_done", bus.done_o, 2'b10);
        tick();
        bus.tcdm_r_valid_i = 1'b0;

        // Only the write channel requests
        bus.req_i = 2'b10;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("solo_gnt%0d", i), bus.gnt_o, 2'b10);
            chk($sformatf("solo_add%0d", i), bus.tcdm_add_o, 32'h200);
            tick();
        end

        // TCDM stalls: nothing granted, selection parked on rr_q=0, no responses
        bus.req_i      = 2'b11;
        bus.tcdm_gnt_i = 1'b0;
        for (int j = 0; j < 3; j++) begin
            bus.tcdm_r_valid_i = (j > 0);
            @(negedge clk);
            chk($sformatf("stall_gnt%0d", j), bus.gnt_o, 2'b00);
            chk($sformatf("stall_req%0d", j), bus.tcdm_req_o, 1'b1);
            chk($sformatf("stall_add%0d", j), bus.tcdm_add_o, 32'h100);
            chk($sformatf("stall_rvalid%0d", j), bus.r_valid_o, 2'b00);
            tick();
        end

        // Four-beat burst on channel 0 with channel 1 pending
        bus.tcdm_gnt_i = 1'b1;
        bus.id_i[0]    = 6'd7;
        bus.id_i[1]    = 6'd3;
        for (int c = 0; c < 5; c++) begin
            bus.req_i          = {1'b1, t4_req0[c]};
            bus.last_i         = {1'b1, t4_last0[c]};
            bus.tcdm_r_valid_i = (c > 0);
            @(negedge clk);
            exp_rv = (c == 0) ? 2'b00 : exp_g[c-1];
            chk($sformatf("burst_gnt%0d", c), bus.gnt_o, exp_g[c]);
            chk($sformatf("burst_rvalid%0d", c), bus.r_valid_o, exp_rv);
            chk($sformatf("burst_done%0d", c), bus.done_o, exp_done[c]);
            if (exp_done[c][0]) chk($sformatf("burst_done_id0_%0d", c), bus.done_id_o[0], 6'd7);
            if (exp_done[c][1]) chk($sformatf("burst_done_id1_%0d", c), bus.done_id_o[1], 6'd3);
            tick();
        end
        bus.req_i          = 2'b00;
        bus.tcdm_r_valid_i = 1'b1;
        @(negedge clk);
        chk("burst_drain_rvalid", bus.r_valid_o, exp_g[4]);
`ifdef AXI2MEM_ARB_BURST_LOCK_EN
        chk("burst_drain_done", bus.done_o, 2'b10);
        chk("burst_held_id0", bus.done_id_o[0], 6'd7);
`else
        chk("burst_drain_done", bus.done_o, 2'b00);
        chk("burst_held_id0", bus.done_id_o[0], 6'd5);
`endif
        tick();
        bus.tcdm_r_valid_i = 1'b0;

        // Reset after beat 2 of a channel-0 burst with its response arriving late
        bus.req_i  = 2'b01;
        bus.last_i = 2'b00;
        for (int b = 0; b < 2; b++) begin
            @(negedge clk);
            chk($sformatf("pre_rst_gnt%0d", b), bus.gnt_o, 2'b01);
            tick();
        end
        rst_n              = 1'b0;
        bus.req_i          = 2'b00;
        bus.tcdm_gnt_i     = 1'b0;
        bus.tcdm_r_valid_i = 1'b1;
        @(negedge clk);
        chk("mid_rst_rvalid", bus.r_valid_o, 2'b00);
        chk("mid_rst_done", bus.done_o, 2'b00);
        chk("mid_rst_gnt", bus.gnt_o, 2'b00);
        chk("mid_rst_done_id", bus.done_id_o, 12'h0);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_rvalid", bus.r_valid_o, 2'b00);
        chk("post_rst_done", bus.done_o, 2'b00);
        tick();
        bus.tcdm_r_valid_i = 1'b0;
        bus.tcdm_gnt_i     = 1'b1;
        bus.last_i         = 2'b11;
`ifdef AXI2MEM_ARB_BURST_LOCK_EN
        bus.req_i = 2'b10;
        @(negedge clk);
        chk("post_rst_unlocked_gnt", bus.gnt_o, 2'b10);
`else
        bus.req_i = 2'b11;
        @(negedge clk);
        chk("post_rst_rr_gnt", bus.gnt_o, 2'b01);
`endif
        tick();
        bus.req_i = 2'b00;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/axi2mem_tcdm_arb.md
AXI2MEM_TCDM_ARB -- requirements
Module: axi2mem_tcdm_arb

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, TCDM byte address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, TCDM data width; BE width = DATA_WIDTH/8.
REQ-003 SHALL have parameter ID_WIDTH, default 6, transaction ID width.
REQ-004 clk_i  in  1  single clock; all logic rising-edge.
REQ-005 rst_ni  in  1  asynchronous active-low reset.
REQ-006 req_i  in  2  per-requester beat request (index 0 = read channel, 1 = write channel).
REQ-007 add_i / wen_i / wdata_i / be_i  in  2xADDR_WIDTH / 2 / 2xDATA_WIDTH / 2xBE  per-requester beat payload; wen=1 means read.
REQ-008 last_i / id_i  in  2 / 2xID_WIDTH  per-requester last-beat flag and transaction ID.
REQ-009 gnt_o  out  2  per-requester beat accepted.
REQ-010 tcdm_req_o / tcdm_add_o / tcdm_wen_o / tcdm_wdata_o / tcdm_be_o  out  1 / ADDR_WIDTH / 1 / DATA_WIDTH / BE  shared TCDM port.
REQ-011 tcdm_gnt_i  in  1  TCDM grant.
REQ-012 tcdm_r_valid_i / tcdm_r_rdata_i  in  1 / DATA_WIDTH  TCDM response, exactly 1 cycle after granted beat.
REQ-013 r_valid_o / r_rdata_o  out  2 / DATA_WIDTH  routed response; r_rdata_o shared by both requesters.
REQ-014 done_o / done_id_o  out  2 / 2xID_WIDTH  one-cycle pulse plus ID when response of a last beat returns (feeds per-channel completion synchroniser).

Function
REQ-015 Arbitration SHALL be round-robin over 2 requesters; pointer rr_q gives priority, reset value 0.
REQ-016 tcdm_req_o SHALL equal req_i of the selected requester, payload muxed combinationally from it (0 latency).
REQ-017 gnt_o[sel] SHALL equal tcdm_gnt_i AND req_i[sel]; unselected gnt_o SHALL be 0.
REQ-018 With both requesting, selected = rr_q; with one requesting, selected = that one regardless of rr_q.
REQ-019 After a granted beat (unlocked mode) rr_q SHALL flip to the other index.
REQ-020 Response tracking: on granted beat, register resp_sel_q = sel, resp_last_q = last_i[sel], resp_id_q = id_i[sel], resp_pend_q = 1; cleared next cycle unless a new beat is granted.
REQ-021 r_valid_o[resp_sel_q] SHALL equal tcdm_r_valid_i AND resp_pend_q; other bit 0; r_rdata_o = tcdm_r_rdata_i.
REQ-022 done_o[resp_sel_q] SHALL pulse when r_valid routed and resp_last_q=1; done_id_o[resp_sel_q] = resp_id_q, held until next done on that index.
REQ-023 Back-to-back grants every cycle SHALL be supported; response of beat N and grant of beat N+1 in same cycle SHALL both be handled.
REQ-024 Ungranted request (tcdm_gnt_i=0) SHALL NOT change rr_q, lock state or response registers.

Reset
REQ-025 On rst_ni low, asynchronously: rr_q=0, state=IDLE, resp_pend_q=0, resp_sel_q=0, resp_last_q=0, resp_id_q=0, done_id_o=0.
REQ-026 During and after reset until first request: gnt_o=0, tcdm_req_o=0, r_valid_o=0, done_o=0.
REQ-027 Reset mid-burst SHALL drop lock and any pending response; a late tcdm_r_valid_i after reset SHALL NOT be routed.

Configuration
REQ-028 Macro AXI2MEM_ARB_BURST_LOCK_EN SHALL select burst locking.
REQ-029 Defined: FSM IDLE/LOCKED; granted non-last beat in IDLE -> LOCKED with owner = sel; in LOCKED only owner is selectable (other gnt_o=0 even if owner idle); granted last beat of owner -> IDLE, rr_q = other index.
REQ-030 Not defined: no FSM, per-beat round-robin per REQ-019; last_i only affects done_o.

Verification
REQ-031 Both req_i=2'b11 continuously, tcdm_gnt_i=1, last=1 each beat -> grants alternate 0,1,0,1; r_valid_o follows one cycle later same order.
REQ-032 Only req_i[1]=1, 4 beats, tcdm_gnt_i=1 -> gnt_o=2'b10 every cycle, rr_q=0 afterward.
REQ-033 tcdm_gnt_i=0 for 3 cycles with both requesting -> gnt_o=0, selection stays at rr_q, no r_valid_o.
REQ-034 LOCK_EN defined: req 0 4-beat burst (last on beat 4) plus req 1 pending -> gnts 0,0,0,0 then 1; done_o[0] pulses with id_i[0] one cycle after beat 4; without macro -> 0,1,0,1 interleave.
REQ-035 Assert rst_ni low after beat 2 of locked burst, response arriving next cycle -> r_valid_o=0, done_o=0, state IDLE, next grant follows rr_q=0.
